// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine.
// Radix-2 shift-add multiply (LSB first) and restoring divide (MSB first).
// Signed operations run on magnitudes; the signs are re-applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;

  // Operands captured on the accepting edge
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;

  // Iteration datapath
  logic [2*WIDTH-1:0] acc_q;   // product accumulator; low half doubles as dividend/quotient
  logic [WIDTH-1:0]   rem_q;   // partial remainder
  logic [WIDTH-1:0]   m_q;     // multiplicand or divisor magnitude
  logic               sgn_q;   // negate product / quotient
  logic               rsgn_q;  // negate remainder

  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic               dbz_q;

  // Two's-complement magnitude of a value, only when the op is signed
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic en);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (en && v[WIDTH-1]) ? $unsigned(n) : $unsigned(v);
  endfunction

  // Conditional negation modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v,
                                              input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  // Conditional negation modulo 2^(2*WIDTH)
  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  logic accept, is_div, is_signed, dbz_hit;
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign dbz_hit   = is_div && (b_q == '0);

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = mag(a_q, is_signed);
  assign mag_b = mag(b_q, is_signed);

  // Multiply step: conditionally add multiplicand to the high half, shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift next dividend bit into the remainder, trial subtract
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] q_next;
  assign rem_shift = {rem_q, acc_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, m_q};
  assign rem_sub   = rem_shift[WIDTH-1:0] - m_q;  // fits in WIDTH bits whenever rem_ge
  assign q_next    = {acc_q[WIDTH-2:0], rem_ge};

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  assign prod_fix = cneg_2w(acc_q, sgn_q);
  assign fix_lo   = is_div ? cneg_w(acc_q[WIDTH-1:0], sgn_q) : prod_fix[WIDTH-1:0];
  assign fix_hi   = is_div ? cneg_w(rem_q, rsgn_q) : prod_fix[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = dbz_hit ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = start ? S_PREP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_PREP, S_ITER, S_FIX: busy = 1'b1;
      S_DONE:                done = 1'b1;
      default: ;
    endcase
  end

  // Iteration counter: cleared entering ITER, advanced once per iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == S_PREP) begin
      cnt_q <= '0;
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result registers: held from DONE until the next FIX or early divide-by-zero DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      if (accept) dbz_q <= 1'b0;
      if (state_q == S_PREP && dbz_hit) begin
        res_lo_q <= '0;
        res_hi_q <= a_q;
        dbz_q    <= 1'b1;
      end
      if (state_q == S_FIX) begin
        res_lo_q <= fix_lo;
        res_hi_q <= fix_hi;
      end
    end
  end

  // Operand capture and iteration datapath (no reset: only meaningful once loaded)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
    case (state_q)
      S_PREP: begin
        sgn_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rsgn_q <= is_signed & a_q[WIDTH-1];
        m_q    <= is_div ? mag_b : mag_a;
        acc_q  <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        rem_q  <= '0;
      end
      S_ITER: begin
        if (is_div) begin
          acc_q <= {acc_q[2*WIDTH-1:WIDTH], q_next};
          rem_q <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
        end else begin
          acc_q <= mul_next;
        end
      end
      default: ;
    endcase
  end

  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule
